// File: rtl/timer_pkg.sv
// Shared definitions for the Wishbone programmable timer:
// bus widths, register offsets, field layouts and reset values.
package timer_pkg;

    localparam int SEL_WIDTH = 4;
    localparam int ADR_WIDTH = 32;
    localparam int DAT_WIDTH = 32;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_STATUS   = 3'd1;
    localparam logic [2:0] OFF_PRESCALE = 3'd2;
    localparam logic [2:0] OFF_COUNT    = 3'd3;
    localparam logic [2:0] OFF_COMPARE  = 3'd4;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic irq_en;
        logic oneshot;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic ovf;
        logic match;
    } status_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider for the timer: one tick every prescale+1 cycles
// while enabled; restarts from zero on clr or while disabled.
module timer_prescaler (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] pre_cnt;

    assign tick = en & (pre_cnt == prescale);

    always_ff @(posedge clk_i) begin
        if (rst_i || !en || clr)
            pre_cnt <= '0;
        else if (tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + 16'd1;
    end

endmodule

// File: rtl/timer.sv
// Wishbone B4 classic slave: 32-bit timer with prescaler,
// compare match, overflow flag and level interrupt.
module timer
    import timer_pkg::*;
#(
    parameter logic [15:0] PRESCALE_RESET = 16'h0000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 timer_stb_i,
    input  logic                 timer_cyc_i,
    input  logic                 timer_we_i,
    input  logic [SEL_WIDTH-1:0] timer_sel_i,
    input  logic [ADR_WIDTH-1:0] timer_adr_i,
    input  logic [DAT_WIDTH-1:0] timer_dat_i,
    output logic [31:0]          timer_dat_o,
    output logic                 timer_ack_o,
    output logic                 timer_err_o,
    output logic                 timer_irq_o
);

    ctrl_t       ctrl;
    status_t     status;
    logic [15:0] prescale;
    logic [31:0] count;
    logic [31:0] compare;

    logic [2:0]  off;
    logic        req, hit, wr;
    logic [31:0] mask, wd, rdata;
    logic        ctrl_wr, stat_wr, pre_wr, cnt_wr, cmp_wr;
    logic [2:0]  ctrl_m;
    logic [1:0]  w1c;
    logic        pre_clr, tick, cnt_tick, is_match;
    logic        hw_match, hw_ovf;
    logic        unused_adr;

    assign unused_adr = ^{timer_adr_i[31:5], timer_adr_i[1:0]};

    assign off  = timer_adr_i[4:2];
    assign req  = timer_stb_i & timer_cyc_i & ~timer_ack_o & ~timer_err_o;
    assign hit  = (off <= OFF_COMPARE);
    assign wr   = req & hit & timer_we_i;
    assign mask = byte_mask(timer_sel_i);
    assign wd   = timer_dat_i & mask;

    assign ctrl_wr = wr & (off == OFF_CTRL);
    assign stat_wr = wr & (off == OFF_STATUS);
    assign pre_wr  = wr & (off == OFF_PRESCALE);
    assign cnt_wr  = wr & (off == OFF_COUNT);
    assign cmp_wr  = wr & (off == OFF_COMPARE);

    assign ctrl_m  = (ctrl & ~mask[2:0]) | wd[2:0];
    assign w1c     = stat_wr ? wd[1:0] : 2'b00;
    assign pre_clr = pre_wr | (ctrl_wr & ~ctrl.en & ctrl_m[0]);

    timer_prescaler u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en       (ctrl.en),
        .clr      (pre_clr),
        .prescale (prescale),
        .tick     (tick)
    );

    // A bus write to COUNT swallows the coincident tick entirely
    assign cnt_tick = tick & ~cnt_wr;
    assign is_match = (count == compare);
    assign hw_match = cnt_tick & is_match;
    assign hw_ovf   = cnt_tick & ~is_match & (count == 32'hFFFF_FFFF);

    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:     rdata = {29'd0, ctrl};
            OFF_STATUS:   rdata = {30'd0, status};
            OFF_PRESCALE: rdata = {16'd0, prescale};
            OFF_COUNT:    rdata = count;
            OFF_COMPARE:  rdata = compare;
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_ack_o <= 1'b0;
            timer_err_o <= 1'b0;
            timer_dat_o <= '0;
            ctrl        <= '0;
            status      <= '0;
            prescale    <= PRESCALE_RESET;
            count       <= '0;
            compare     <= COMPARE_RST;
        end else begin
            timer_ack_o <= req & hit;
            timer_err_o <= req & ~hit;
            timer_dat_o <= (req & hit & ~timer_we_i) ? rdata : '0;

            if (ctrl_wr)
                ctrl <= ctrl_t'(ctrl_m);
            else if (hw_match && ctrl.oneshot)
                ctrl.en <= 1'b0;

            // Hardware set beats a coincident write-one-to-clear
            status <= status_t'((status & ~w1c) | {hw_ovf, hw_match});

            if (pre_wr)
                prescale <= (prescale & ~mask[15:0]) | wd[15:0];
            if (cmp_wr)
                compare <= (compare & ~mask) | wd;

            if (cnt_wr)
                count <= (count & ~mask) | wd;
            else if (cnt_tick)
                count <= is_match ? 32'd0 : count + 32'd1;
        end
    end

    assign timer_irq_o = status.match & ctrl.irq_en;

endmodule

// File: tb/tb_timer.sv
// Randomized and directed bench for timer, checked every cycle
// against a behavioural model of the register/tick rules.
module tb_timer;

    localparam logic [15:0] PRST = 16'h0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic [31:0] dout;
    logic        ack, err, irq;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit          m_en, m_os, m_ie, m_mt, m_ov;
    int          m_ps;
    logic [31:0] m_cnt, m_cmp;
    int          m_ph;
    bit          m_ack, m_err;
    logic [31:0] m_dat;

    timer #(.PRESCALE_RESET(PRST)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .timer_stb_i (stb),
        .timer_cyc_i (cyc),
        .timer_we_i  (we),
        .timer_sel_i (sel),
        .timer_adr_i (adr),
        .timer_dat_i (dat),
        .timer_dat_o (dout),
        .timer_ack_o (ack),
        .timer_err_o (err),
        .timer_irq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] o);
        case (o)
            3'd0:    return {29'd0, m_ie, m_os, m_en};
            3'd1:    return {30'd0, m_ov, m_mt};
            3'd2:    return 32'(m_ps);
            3'd3:    return m_cnt;
            3'd4:    return m_cmp;
            default: return 32'd0;
        endcase
    endfunction

    // Advance model and DUT by one clock, then compare outputs
    task automatic step();
        bit          req, hit, wr, tick, clr;
        logic [2:0]  o;
        logic [31:0] mk, mg, w1c;
        bit          n_en, n_os, n_ie, n_mt, n_ov, n_ack, n_err;
        int          n_ps, n_ph;
        logic [31:0] n_cnt, n_cmp, n_dat;
        o   = adr[4:2];
        mk  = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        mg  = (m_read(o) & ~mk) | (dat & mk);
        req = stb && cyc && !m_ack && !m_err;
        hit = (o < 3'd5);
        wr  = req && hit && we;
        if (rst) begin
            {n_en, n_os, n_ie, n_mt, n_ov} = '0;
            n_ps = int'(PRST); n_cnt = 0; n_cmp = 32'hFFFF_FFFF;
            n_ph = 0; n_ack = 0; n_err = 0; n_dat = 0;
        end else begin
            tick = m_en && ((m_ph % (m_ps + 1)) == m_ps);
            {n_en, n_os, n_ie, n_mt, n_ov} = {m_en, m_os, m_ie, m_mt, m_ov};
            n_ps = m_ps; n_cnt = m_cnt; n_cmp = m_cmp;
            w1c = 0;
            if (tick && !(wr && o == 3'd3)) begin
                if (m_cnt == m_cmp) begin
                    n_cnt = 0;
                    if (m_os) n_en = 0;
                end else begin
                    n_cnt = m_cnt + 1;
                end
            end
            if (wr) begin
                case (o)
                    3'd0: {n_ie, n_os, n_en} = mg[2:0];
                    3'd1: w1c = dat & mk;
                    3'd2: n_ps = int'(mg[15:0]);
                    3'd3: n_cnt = mg;
                    default: n_cmp = mg;
                endcase
            end
            n_mt = m_mt && !w1c[0];
            n_ov = m_ov && !w1c[1];
            if (tick && !(wr && o == 3'd3)) begin
                if (m_cnt == m_cmp) n_mt = 1;
                else if (m_cnt == 32'hFFFF_FFFF) n_ov = 1;
            end
            clr  = wr && (o == 3'd2 || (o == 3'd0 && !m_en && mg[0]));
            n_ph = (!m_en || clr) ? 0 : m_ph + 1;
            n_ack = req && hit;
            n_err = req && !hit;
            n_dat = (req && hit && !we) ? m_read(o) : 32'd0;
        end
        @(posedge clk);
        {m_en, m_os, m_ie, m_mt, m_ov} = {n_en, n_os, n_ie, n_mt, n_ov};
        m_ps = n_ps; m_cnt = n_cnt; m_cmp = n_cmp; m_ph = n_ph;
        m_ack = n_ack; m_err = n_err; m_dat = n_dat;
        #1;
        check("ack", {31'd0, ack}, {31'd0, m_ack});
        check("err", {31'd0, err}, {31'd0, m_err});
        check("dat_o", dout, m_dat);
        check("irq", {31'd0, irq}, {31'd0, m_mt & m_ie});
    endtask

    task automatic bus(input bit w, input logic [2:0] o,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] q);
        bit   done;
        logic [31:0] a;
        a   = $urandom;
        stb = 1; cyc = 1; we = w; sel = s; dat = d;
        adr = {a[31:5], o, a[1:0]};
        done = 0;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            if (ack || err) done = 1;
        end
        q = dout;
        stb = 0; cyc = 0; we = 0;
        if (!done) check("bus_timeout", 32'd0, 32'd1);
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d);
        logic [31:0] q;
        bus(1, o, d, 4'hF, q);
    endtask

    task automatic rd(input logic [2:0] o, output logic [31:0] q);
        bus(0, o, 32'd0, 4'hF, q);
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] d;
        logic [2:0]  o;
        logic [3:0]  s;
        int          k;

        rst = 1;
        step();
        step();
        rst = 0;
        rd(0, q); check("rst_ctrl", q, 32'd0);
        rd(1, q); check("rst_status", q, 32'd0);
        rd(2, q); check("rst_prescale", q, {16'd0, PRST});
        rd(3, q); check("rst_count", q, 32'd0);
        rd(4, q); check("rst_compare", q, 32'hFFFF_FFFF);
        check("rst_irq", {31'd0, irq}, 32'd0);

        wr(2, 3); wr(4, 4); wr(0, 5);
        k = 0;
        while (!irq && k < 100) begin step(); k++; end
        check("periodic_lat", 32'(k), 32'd20);
        rd(3, q); check("periodic_cnt", q, 32'd0);
        rd(0, q); check("periodic_en", q, 32'd5);

        wr(0, 0); wr(1, 3); wr(3, 0); wr(2, 0); wr(4, 2); wr(0, 3);
        repeat (10) step();
        rd(0, q); check("oneshot_ctrl", q, 32'd2);
        rd(3, q); check("oneshot_cnt", q, 32'd0);
        rd(1, q); check("oneshot_stat", q, 32'd1);
        wr(0, 4); check("irq_on", {31'd0, irq}, 32'd1);
        wr(1, 1); check("irq_w1c", {31'd0, irq}, 32'd0);

        bus(1, 3, 32'h1234_56AB, 4'b0001, q);
        rd(3, q); check("sel_count", q, 32'h0000_00AB);

        wr(1, 3); wr(3, 32'hFFFF_FFFF); wr(4, 0); wr(2, 0); wr(0, 1);
        rd(1, q); check("ovf_status", q, 32'd2);
        rd(3, q); check("ovf_count", q, 32'd0);

        wr(0, 0); wr(4, 32'hFFFF_FFFF); wr(2, 0); wr(0, 1);
        wr(3, 32'h1000);
        rd(3, q); check("cnt_conflict", q, 32'h1001);

        wr(0, 0); wr(3, 0); wr(4, 0); wr(0, 5);
        wr(1, 1); check("w1c_conflict", {31'd0, irq}, 32'd1);

        wr(0, 0);
        bus(0, 6, 32'd0, 4'hF, q);
        check("err_flag", {31'd0, err}, 32'd1);
        check("err_ack", {31'd0, ack}, 32'd0);
        check("err_dat", q, 32'd0);
        step();
        check("err_drop", {31'd0, err}, 32'd0);

        wr(1, 3); wr(3, 0); wr(2, 1); wr(4, 6);
        for (int i = 0; i < 400; i++) begin
            o = 3'($urandom_range(0, 7));
            s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            case (o)
                3'd2:    d = 32'($urandom_range(0, 3));
                3'd4:    d = 32'($urandom_range(0, 12));
                3'd3:    d = ($urandom_range(0, 4) == 0) ?
                             32'hFFFF_FFFE : 32'($urandom_range(0, 8));
                default: d = $urandom;
            endcase
            bus(1'($urandom), o, d, s, q);
            repeat ($urandom_range(0, 3)) step();
        end

        wr(0, 5);
        stb = 1; cyc = 1; we = 0; adr = 32'h0; sel = 4'hF;
        rst = 1;
        step();
        check("midrst_ack", {31'd0, ack}, 32'd0);
        rst = 0; stb = 0; cyc = 0;
        rd(0, q); check("midrst_ctrl", q, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
